// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush controller for the 5-stage RV32 pipeline.
// Resolves load-use hazards, MEM-stage redirects and data-memory waits.
// Bounds every memory wait with a timeout FSM and keeps saturating performance counters.
module pipeline_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1_addr,
  input  logic [4:0]       id_rs2_addr,
  input  logic             id_rs1_used,
  input  logic             id_rs2_used,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rd_addr,
  input  logic             mem_branch_taken,
  input  logic             mem_jump,
  input  logic             mem_access,
  input  logic             dmem_ready,
  output logic             pc_stall,
  output logic             if_id_stall,
  output logic             id_ex_stall,
  output logic             ex_mem_stall,
  output logic             mem_wb_stall,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_flush,
  output logic             mem_wb_flush,
  output logic             pc_redirect,
  output logic             mem_fault,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
);

  localparam int WCNT_W = $clog2(MEM_TIMEOUT) + 1;
  // wcnt holds the stall cycles already served before the current one, so
  // reaching MEM_TIMEOUT-1 in WAIT means this cycle is the last allowed stall.
  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(MEM_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RELEASE} state_t;

  state_t            state;
  logic [WCNT_W-1:0] wcnt;
  logic              mem_wait;
  logic              redirect;
  logic              load_use;
  logic              rs1_hit;
  logic              rs2_hit;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    if (en && (v != {CNT_W{1'b1}}))
      return v + {{(CNT_W-1){1'b0}}, 1'b1};
    return v;
  endfunction

  assign rs1_hit  = id_rs1_used && (id_rs1_addr == ex_rd_addr);
  assign rs2_hit  = id_rs2_used && (id_rs2_addr == ex_rd_addr);
  // RELEASE lets the stuck access through for one cycle with whatever data is present.
  assign mem_wait = mem_access && !dmem_ready && (state != RELEASE);
  assign redirect = (mem_branch_taken || mem_jump) && !mem_wait;
  assign load_use = ex_mem_read && (ex_rd_addr != 5'd0) && (rs1_hit || rs2_hit)
                    && !mem_wait && !redirect;

  // Same-cycle control decode; everything held low while in reset.
  always_comb begin
    pc_stall     = 1'b0;
    if_id_stall  = 1'b0;
    id_ex_stall  = 1'b0;
    ex_mem_stall = 1'b0;
    mem_wb_stall = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    mem_wb_flush = 1'b0;
    pc_redirect  = 1'b0;
    if (!rst) begin
      if (mem_wait) begin
        pc_stall     = 1'b1;
        if_id_stall  = 1'b1;
        id_ex_stall  = 1'b1;
        ex_mem_stall = 1'b1;
        mem_wb_flush = 1'b1;
      end else if (redirect) begin
        pc_redirect  = 1'b1;
        if_id_flush  = 1'b1;
        id_ex_flush  = 1'b1;
        ex_mem_flush = 1'b1;
      end else if (load_use) begin
        pc_stall     = 1'b1;
        if_id_stall  = 1'b1;
        id_ex_flush  = 1'b1;
      end
    end
  end

  // Memory-wait timeout FSM with sticky fault flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      wcnt      <= '0;
      mem_fault <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (mem_wait) begin
            wcnt  <= WCNT_W'(1);
            state <= WAIT;
          end
        end
        WAIT: begin
          if (dmem_ready || !mem_access) begin
            state <= IDLE;
            wcnt  <= '0;
          end else if (wcnt == WCNT_LAST) begin
            state     <= RELEASE;
            mem_fault <= 1'b1;
          end else begin
            wcnt <= wcnt + WCNT_W'(1);
          end
        end
        RELEASE: begin
          state <= IDLE;
          wcnt  <= '0;
        end
        default: begin
          state <= IDLE;
          wcnt  <= '0;
        end
      endcase
    end
  end

  // Saturating performance counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= '0;
      flush_events <= '0;
    end else begin
      stall_cycles <= sat_inc(stall_cycles, pc_stall);
      flush_events <= sat_inc(flush_events, pc_redirect);
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed scenarios followed by random
// traffic, all compared against a cycle-level behavioural model.
module tb_pipeline_hazard_ctrl;

  localparam int T    = 4;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [4:0]    id_rs1_addr, id_rs2_addr, ex_rd_addr;
  logic          id_rs1_used, id_rs2_used, ex_mem_read;
  logic          mem_branch_taken, mem_jump, mem_access, dmem_ready;
  logic          pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, mem_wb_stall;
  logic          if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush, pc_redirect;
  logic          mem_fault;
  logic [CW-1:0] stall_cycles, flush_events;
  logic [9:0]    ctrl;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(T), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .ex_mem_read(ex_mem_read), .ex_rd_addr(ex_rd_addr),
    .mem_branch_taken(mem_branch_taken), .mem_jump(mem_jump),
    .mem_access(mem_access), .dmem_ready(dmem_ready),
    .pc_stall(pc_stall), .if_id_stall(if_id_stall), .id_ex_stall(id_ex_stall),
    .ex_mem_stall(ex_mem_stall), .mem_wb_stall(mem_wb_stall),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .ex_mem_flush(ex_mem_flush), .mem_wb_flush(mem_wb_flush),
    .pc_redirect(pc_redirect), .mem_fault(mem_fault),
    .stall_cycles(stall_cycles), .flush_events(flush_events)
  );

  assign ctrl = {pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, mem_wb_stall,
                 if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush, pc_redirect};

  int n_chk  = 0;
  int n_pass = 0;

  // Model state: whether the next cycle is the forced-release cycle, how many
  // consecutive wait cycles have elapsed, the fault flag and the counters.
  bit m_release;
  int m_waited;
  bit m_fault;
  int m_stalls;
  int m_flushes;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic model_reset();
    m_release = 1'b0;
    m_waited  = 0;
    m_fault   = 1'b0;
    m_stalls  = 0;
    m_flushes = 0;
  endtask

  task automatic clr();
    rst = 1'b0;
    id_rs1_addr = '0; id_rs2_addr = '0; ex_rd_addr = '0;
    id_rs1_used = 1'b0; id_rs2_used = 1'b0; ex_mem_read = 1'b0;
    mem_branch_taken = 1'b0; mem_jump = 1'b0; mem_access = 1'b0; dmem_ready = 1'b0;
  endtask

  // Called at a falling edge with inputs already applied: check, clock, advance model.
  task automatic run_cycle(input string tag);
    bit w, rd, lu;
    logic [9:0] exp_ctrl;
    #1;
    w  = mem_access && !dmem_ready && !m_release;
    rd = (mem_branch_taken || mem_jump) && !w;
    lu = ex_mem_read && (ex_rd_addr != 0) &&
         ((id_rs1_used && id_rs1_addr == ex_rd_addr) ||
          (id_rs2_used && id_rs2_addr == ex_rd_addr)) && !w && !rd;
    if (rst)     exp_ctrl = 10'b00000_00000;
    else if (w)  exp_ctrl = 10'b11110_00010;
    else if (rd) exp_ctrl = 10'b00000_11101;
    else if (lu) exp_ctrl = 10'b11000_01000;
    else         exp_ctrl = 10'b00000_00000;
    chk({tag, ".ctrl"},   32'(ctrl),         32'(exp_ctrl));
    chk({tag, ".stalls"}, 32'(stall_cycles), 32'(m_stalls));
    chk({tag, ".flush"},  32'(flush_events), 32'(m_flushes));
    chk({tag, ".fault"},  32'(mem_fault),    32'(m_fault));
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      if (m_release) begin
        m_release = 1'b0;
        m_waited  = 0;
      end else if (w) begin
        m_waited++;
        if (m_waited == T) begin
          m_release = 1'b1;
          m_fault   = 1'b1;
          m_waited  = 0;
        end
      end else begin
        m_waited = 0;
      end
      if (exp_ctrl[9] && m_stalls < CMAX)  m_stalls++;
      if (exp_ctrl[0] && m_flushes < CMAX) m_flushes++;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    clr();
    rst = 1'b1;
    run_cycle("rst");
    rst = 1'b0;
  endtask

  initial begin
    clr();
    rst = 1'b1;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    run_cycle("rst0");
    run_cycle("rst1");
    rst = 1'b0;
    run_cycle("idle");

    // load-use on rs1, then no hazard with x0 or with rs1 unused
    ex_mem_read = 1'b1; ex_rd_addr = 5'd5; id_rs1_addr = 5'd5; id_rs1_used = 1'b1;
    run_cycle("lu");
    clr();
    run_cycle("lu_after");
    chk("lu_count", 32'(stall_cycles), 32'd1);
    ex_mem_read = 1'b1; ex_rd_addr = 5'd0; id_rs1_addr = 5'd0; id_rs1_used = 1'b1;
    run_cycle("lu_x0");
    ex_rd_addr = 5'd5; id_rs1_addr = 5'd5; id_rs1_used = 1'b0;
    run_cycle("lu_unused");
    id_rs2_addr = 5'd5; id_rs2_used = 1'b1;
    run_cycle("lu_rs2");
    clr();

    // redirect alone and together with a load-use hazard
    do_reset();
    mem_jump = 1'b1;
    run_cycle("jmp");
    clr();
    run_cycle("jmp_after");
    chk("jmp_count", 32'(flush_events), 32'd1);
    mem_branch_taken = 1'b1; ex_mem_read = 1'b1; ex_rd_addr = 5'd7;
    id_rs1_addr = 5'd7; id_rs1_used = 1'b1;
    run_cycle("br_lu");
    clr();

    // three-cycle memory wait, released by ready
    do_reset();
    mem_access = 1'b1;
    for (int i = 0; i < 3; i++) run_cycle("mw");
    dmem_ready = 1'b1;
    run_cycle("mw_ready");
    clr();
    run_cycle("mw_idle");
    chk("mw_fault", 32'(mem_fault), 32'd0);
    chk("mw_stalls", 32'(stall_cycles), 32'd3);

    // ready in the same cycle as access: no stall at all
    mem_access = 1'b1; dmem_ready = 1'b1;
    run_cycle("mw_zero");
    clr();

    // timeout: T stall cycles, then one release cycle, fault sticky
    do_reset();
    mem_access = 1'b1;
    for (int i = 0; i < T; i++) run_cycle("to");
    chk("to_fault", 32'(mem_fault), 32'd1);
    chk("to_release", 32'(pc_stall), 32'd0);
    run_cycle("to_rel");
    run_cycle("to_again");
    clr();
    run_cycle("to_idle");
    chk("to_sticky", 32'(mem_fault), 32'd1);

    // mem wait beats a redirect, which proceeds when ready arrives
    do_reset();
    mem_access = 1'b1; mem_branch_taken = 1'b1;
    run_cycle("pri_w0");
    run_cycle("pri_w1");
    dmem_ready = 1'b1;
    run_cycle("pri_ready");
    clr();
    run_cycle("pri_idle");

    // reset in the middle of a wait that would otherwise time out
    mem_access = 1'b1;
    for (int i = 0; i < T - 1; i++) run_cycle("rmw");
    rst = 1'b1;
    run_cycle("rmw_rst");
    rst = 1'b0;
    for (int i = 0; i < 2; i++) run_cycle("rmw_post");
    chk("rmw_fault", 32'(mem_fault), 32'd0);
    clr();

    // counter saturation
    do_reset();
    ex_mem_read = 1'b1; ex_rd_addr = 5'd3; id_rs2_addr = 5'd3; id_rs2_used = 1'b1;
    for (int i = 0; i < 20; i++) run_cycle("sat");
    chk("sat_hold", 32'(stall_cycles), 32'(CMAX));
    clr();

    // random traffic
    do_reset();
    for (int i = 0; i < 600; i++) begin
      rst              = ($urandom_range(0, 59) == 0);
      id_rs1_addr      = 5'($urandom_range(0, 3));
      id_rs2_addr      = 5'($urandom_range(0, 3));
      ex_rd_addr       = 5'($urandom_range(0, 3));
      id_rs1_used      = 1'($urandom_range(0, 1));
      id_rs2_used      = 1'($urandom_range(0, 1));
      ex_mem_read      = 1'($urandom_range(0, 1));
      mem_branch_taken = ($urandom_range(0, 5) == 0);
      mem_jump         = ($urandom_range(0, 7) == 0);
      mem_access       = ($urandom_range(0, 3) != 0);
      dmem_ready       = ($urandom_range(0, 3) == 0);
      run_cycle("rnd");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
